demux_stream_scheduler: RTL and testbench

Sequencer for the 1-to-4 demultiplexer datapath. Accepts a word stream on a valid/ready input, picks a destination channel (round-robin with bursts, or explicitly addressed), drives the 2-bit demux select, and holds the word until that channel's ready completes the transfer. Sits between a single producer and four consumer channels; sel[1:0] drives the demux select lines (sel[1] = s1, sel[0] = s0).

---
 rtl/demux_stream_scheduler_if.sv | 27 ++
 rtl/demux_stream_scheduler.sv | 151 +++++++++++++++
 tb/tb_demux_stream_scheduler.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_scheduler_if.sv
// Handshake bundle between the producer, the stream scheduler and the four
// consumer channels of the 1-to-4 demux datapath.
interface demux_stream_scheduler_if #(
  parameter int DATA_W = 8
);
  logic              mode;
  logic [1:0]        in_dest;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        chan_mask;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [1:0]        sel;
  logic              busy;

  modport master (
    output mode, in_dest, in_data, in_valid, chan_mask, out_ready,
    input  in_ready, out_data, out_valid, sel, busy
  );

  modport slave (
    input  mode, in_dest, in_data, in_valid, chan_mask, out_ready,
    output in_ready, out_data, out_valid, sel, busy
  );
endinterface

// File: rtl/demux_stream_scheduler.sv
// Stream sequencer for the 1-to-4 demux: picks a destination (round-robin
// bursts or addressed), drives the select lines and holds each word until delivered.
module demux_stream_scheduler #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  demux_stream_scheduler_if.slave bus
);

  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [BCW-1:0]    burst_q, burst_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              rr_q, rr_d;
  logic [3:0]        mask_q, mask_d;
  logic              in_ready_s;
  logic [1:0]        dest_s;

  // First enabled channel after p in rotation order; p itself if no other is enabled.
  function automatic logic [1:0] next_en(input logic [1:0] p, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] c;
    logic       found;
    r     = p;
    found = 1'b0;
    for (int k = 1; k < 4; k++) begin
      c = p + 2'(k);
      if (!found && m[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Next-state, destination choice and burst bookkeeping.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    data_d     = data_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    rr_d       = rr_q;
    mask_d     = mask_q;
    in_ready_s = 1'b0;
    if (bus.mode) begin
      dest_s = bus.in_dest;
    end else if (bus.chan_mask[ptr_q]) begin
      dest_s = ptr_q;
    end else begin
      dest_s = next_en(ptr_q, bus.chan_mask);
    end

    case (state_q)
      IDLE: begin
        if (bus.mode) begin
          in_ready_s = bus.chan_mask[bus.in_dest];
        end else begin
          in_ready_s = |bus.chan_mask;
        end
        if (bus.in_valid && in_ready_s && rst_n) begin
          state_d = HOLD;
          data_d  = bus.in_data;
          sel_d   = dest_s;
          valid_d = 4'b0001 << dest_s;
          busy_d  = 1'b1;
          rr_d    = ~bus.mode;
          mask_d  = bus.chan_mask;
          if (!bus.mode && (dest_s != ptr_q)) begin
            ptr_d   = dest_s;
            burst_d = '0;
          end else begin
            ptr_d = ptr_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.out_ready[sel_q]) begin
          state_d = IDLE;
          valid_d = 4'b0000;
          busy_d  = 1'b0;
          // Only round-robin words count toward the burst; rotation uses the mask seen at accept.
          if (rr_q) begin
            if (burst_q == BURST_LAST) begin
              burst_d = '0;
              ptr_d   = next_en(ptr_q, mask_q);
            end else begin
              burst_d = burst_q + BCW'(1);
            end
          end else begin
            burst_d = burst_q;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      burst_q <= '0;
      data_q  <= '0;
      sel_q   <= 2'd0;
      valid_q <= 4'b0000;
      busy_q  <= 1'b0;
      rr_q    <= 1'b0;
      mask_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.in_ready  = in_ready_s & rst_n;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_demux_stream_scheduler.sv
// Randomized and directed bench for demux_stream_scheduler, checked every
// cycle against a behavioural model of the scheduling rules.
module tb_demux_stream_scheduler;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst_n;
  demux_stream_scheduler_if #(.DATA_W(DATA_W)) bus ();

  demux_stream_scheduler #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  bit          m_hold;
  logic [7:0]  m_data;
  int          m_dest;
  int          m_ptr;
  int          m_cnt;
  bit          m_rr;
  logic [3:0]  m_mask;
  bit          accepted;
  int          obs_ch[$];
  int          obs_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int nxt(input int p, input logic [3:0] m);
    for (int k = 1; k < 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_hold = 1'b0;
    m_data = 8'h00;
    m_dest = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    m_rr   = 1'b0;
    m_mask = 4'b0000;
  endtask

  // Inputs are already set by the caller; check outputs, advance model across one posedge.
  task automatic step();
    bit exp_rdy;
    int d;
    #1;
    if (!m_hold && rst_n)
      exp_rdy = bus.mode ? bus.chan_mask[bus.in_dest] : (bus.chan_mask != 4'b0000);
    else
      exp_rdy = 1'b0;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {28'd0, bus.out_valid}, m_hold ? (32'd1 << m_dest) : 32'd0);
    chk("busy", {31'd0, bus.busy}, {31'd0, m_hold});
    chk("sel", {30'd0, bus.sel}, m_dest);
    chk("out_data", {24'd0, bus.out_data}, {24'd0, m_data});
    if (bus.out_valid != 4'b0000 && (bus.out_valid & bus.out_ready) != 4'b0000 && rst_n) begin
      obs_ch.push_back(int'(bus.sel));
      obs_data.push_back(int'(bus.out_data));
    end
    accepted = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_hold) begin
      if (bus.in_valid && exp_rdy) begin
        accepted = 1'b1;
        if (bus.mode) d = int'(bus.in_dest);
        else d = bus.chan_mask[m_ptr] ? m_ptr : nxt(m_ptr, bus.chan_mask);
        if (!bus.mode && d != m_ptr) begin
          m_ptr = d;
          m_cnt = 0;
        end
        m_hold = 1'b1;
        m_data = bus.in_data;
        m_dest = d;
        m_rr   = !bus.mode;
        m_mask = bus.chan_mask;
      end
    end else if (bus.out_ready[m_dest]) begin
      m_hold = 1'b0;
      if (m_rr) begin
        if (m_cnt == MAX_BURST - 1) begin
          m_cnt = 0;
          m_ptr = nxt(m_ptr, m_mask);
        end else begin
          m_cnt++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_ch.delete();
    obs_data.delete();
  endtask

  // Stream n words 0..n-1 in round-robin mode with all consumers ready.
  task automatic rr_stream(input int n);
    int sent;
    sent          = 0;
    bus.mode      = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 4'b1111;
    bus.in_data   = 8'h00;
    for (int c = 0; c < 4 * n + 8 && sent < n; c++) begin
      step();
      if (accepted) begin
        sent++;
        bus.in_data = 8'(sent);
      end
    end
    chk("rr_sent", sent, n);
    bus.in_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    model_reset();
    rst_n         = 1'b0;
    bus.mode      = 1'b0;
    bus.in_dest   = 2'd0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b1;
    bus.chan_mask = 4'b1111;
    bus.out_ready = 4'b0000;
    @(negedge clk);

    // reset with in_valid high
    step();
    step();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // round-robin bursts
    clear_obs();
    rr_stream(10);
    chk("rr_count", obs_ch.size(), 10);
    for (int k = 0; k < 10 && k < obs_ch.size(); k++) begin
      chk($sformatf("rr_ch%0d", k), obs_ch[k], k / 4);
      chk($sformatf("rr_data%0d", k), obs_data[k], k);
    end

    // addressed word to a stalled consumer
    clear_obs();
    bus.mode      = 1'b1;
    bus.in_dest   = 2'd2;
    bus.in_data   = 8'hA5;
    bus.in_valid  = 1'b1;
    bus.out_ready = 4'b0000;
    step();
    bus.in_valid = 1'b0;
    bus.mode     = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("addr_valid", {28'd0, bus.out_valid}, 32'h4);
      chk("addr_data", {24'd0, bus.out_data}, 32'hA5);
      step();
    end
    bus.out_ready = 4'b0100;
    step();
    chk("addr_done_busy", {31'd0, bus.busy}, 32'd0);
    chk("addr_deliv", obs_data.size(), 1);
    // round-robin position is untouched: two more words still go to ch2, then ch3
    clear_obs();
    rr_stream(3);
    chk("addr_ptr_a", (obs_ch.size() > 0) ? obs_ch[0] : -1, 2);
    chk("addr_ptr_b", (obs_ch.size() > 2) ? obs_ch[2] : -1, 3);

    // addressed to a masked channel
    bus.mode      = 1'b1;
    bus.in_dest   = 2'd2;
    bus.chan_mask = 4'b1011;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    bus.out_ready = 4'b0000;
    for (int c = 0; c < 4; c++) step();
    chk("blocked_busy", {31'd0, bus.busy}, 32'd0);
    bus.chan_mask = 4'b1111;
    step();
    chk("unblocked_busy", {31'd0, bus.busy}, 32'd1);
    chk("unblocked_sel", {30'd0, bus.sel}, 32'd2);
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b1111;
    step();

    // masked skip after reset
    rst_n = 1'b0;
    step();
    rst_n         = 1'b1;
    bus.chan_mask = 4'b1010;
    clear_obs();
    rr_stream(9);
    chk("skip_count", obs_ch.size(), 9);
    for (int k = 0; k < 9 && k < obs_ch.size(); k++)
      chk($sformatf("skip_ch%0d", k), obs_ch[k], (k >= 4 && k < 8) ? 3 : 1);

    // reset while holding a word
    clear_obs();
    bus.chan_mask = 4'b1111;
    bus.mode      = 1'b0;
    bus.in_data   = 8'h3C;
    bus.in_valid  = 1'b1;
    bus.out_ready = 4'b0000;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("hold3c_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_hold_valid", {28'd0, bus.out_valid}, 32'd0);
    chk("rst_hold_busy", {31'd0, bus.busy}, 32'd0);
    bus.out_ready = 4'b1111;
    for (int c = 0; c < 4; c++) step();
    chk("rst_hold_nodeliv", obs_data.size(), 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      bus.mode      = ($urandom_range(0, 3) == 0);
      bus.in_dest   = 2'($urandom_range(0, 3));
      bus.in_data   = 8'($urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.chan_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : bus.chan_mask;
      bus.out_ready = 4'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
